// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready on both sides.
// Stage k applies a shift of 2^k when sh_amt[k] is set, so a full shift
// takes one cycle per amount bit. A single global enable stalls every stage
// together when the consumer holds off. Bubbles are not squeezed out.
module barrel_shifter_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   sh_amt,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout
);

  localparam logic [1:0] MODE_ROT  = 2'b00;
  localparam logic [1:0] MODE_LSH  = 2'b01;
  localparam logic [1:0] MODE_ASH  = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  // Stage registers. Each stage carries its operation sideband so that
  // later stages know how to shift.
  logic [WIDTH-1:0] data_reg  [SHW];
  logic [SHW-1:0]   amt_reg   [SHW];
  logic             dir_reg   [SHW];
  logic [1:0]       mode_reg  [SHW];
  logic             valid_reg [SHW];

  // Stage inputs: stage 0 from the ports, stage k from register k-1.
  logic [WIDTH-1:0] stg_data  [SHW];
  logic [SHW-1:0]   stg_amt   [SHW];
  logic             stg_dir   [SHW];
  logic [1:0]       stg_mode  [SHW];
  logic             stg_valid [SHW];
  logic [WIDTH-1:0] stg_next  [SHW];

  logic en;

  // The whole pipe advances unless a finished result is waiting on the
  // consumer; in_ready is therefore combinational from out_ready.
  assign en        = !valid_reg[SHW-1] || out_ready;
  assign in_ready  = en;
  assign out_valid = valid_reg[SHW-1];
  assign dout      = data_reg[SHW-1];

  // Route each stage's input from the ports or from the previous stage.
  always_comb begin
    stg_data[0]  = din;
    stg_amt[0]   = sh_amt;
    stg_dir[0]   = dir;
    stg_mode[0]  = mode;
    stg_valid[0] = in_valid;
    for (int k = 1; k < SHW; k++) begin
      stg_data[k]  = data_reg[k-1];
      stg_amt[k]   = amt_reg[k-1];
      stg_dir[k]   = dir_reg[k-1];
      stg_mode[k]  = mode_reg[k-1];
      stg_valid[k] = valid_reg[k-1];
    end
  end

  // Per-stage shift by 2^k. Arithmetic right uses the current MSB, which is
  // still the original sign because earlier stages preserved it.
  always_comb begin
    for (int k = 0; k < SHW; k++) begin
      stg_next[k] = stg_data[k];
      if (stg_amt[k][k] && (stg_mode[k] != MODE_PASS)) begin
        case (stg_mode[k])
          MODE_ROT: begin
            if (stg_dir[k])
              stg_next[k] = (stg_data[k] >> (1 << k)) | (stg_data[k] << (WIDTH - (1 << k)));
            else
              stg_next[k] = (stg_data[k] << (1 << k)) | (stg_data[k] >> (WIDTH - (1 << k)));
          end
          MODE_LSH: begin
            if (stg_dir[k])
              stg_next[k] = stg_data[k] >> (1 << k);
            else
              stg_next[k] = stg_data[k] << (1 << k);
          end
          MODE_ASH: begin
            if (stg_dir[k])
              stg_next[k] = $signed(stg_data[k]) >>> (1 << k);
            else
              stg_next[k] = stg_data[k] << (1 << k);
          end
          default: stg_next[k] = stg_data[k];
        endcase
      end
    end
  end

  // Stage registers: reset discards everything in flight, else load on en.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SHW; k++) begin
        data_reg[k]  <= '0;
        amt_reg[k]   <= '0;
        dir_reg[k]   <= 1'b0;
        mode_reg[k]  <= 2'b00;
        valid_reg[k] <= 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < SHW; k++) begin
        data_reg[k]  <= stg_next[k];
        amt_reg[k]   <= stg_amt[k];
        dir_reg[k]   <= stg_dir[k];
        mode_reg[k]  <= stg_mode[k];
        valid_reg[k] <= stg_valid[k];
      end
    end
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe at WIDTH = 8: hand-computed vectors,
// streaming, backpressure, reset mid-flight and a full sweep against a
// bit-level reference function.
module tb_barrel_shifter_pipe;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic [SHW-1:0]   sh_amt;
  logic             dir;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [WIDTH-1:0] exp_q [$];
  int               out_cyc_q [$];
  int               acc_cyc_q [$];
  string            phase = "reset";

  barrel_shifter_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .sh_amt    (sh_amt),
    .dir       (dir),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Independent bit-by-bit reference for one operation.
  function automatic logic [7:0] ref_op(logic [7:0] d, int a, logic r, logic [1:0] m);
    logic [7:0] res;
    res = d;
    if (m == 2'b00) begin
      for (int i = 0; i < 8; i++)
        if (r) res[i] = d[(i + a) % 8];
        else   res[(i + a) % 8] = d[i];
    end else if (m == 2'b01 || m == 2'b10) begin
      for (int i = 0; i < 8; i++) begin
        if (r) res[i] = (i + a < 8) ? d[i + a] : ((m == 2'b10) ? d[7] : 1'b0);
        else   res[i] = (i >= a) ? d[i - a] : 1'b0;
      end
    end
    return res;
  endfunction

  // Output monitor: at the negedge before a transfer edge, pop and compare.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check({"unexpected_out_", phase}, {24'h0, dout}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check({"dout_", phase}, {24'h0, dout}, {24'h0, e});
          $display("[%0d] %s out dout=0x%02h exp=0x%02h", cyc, phase, dout, e);
        end
        out_cyc_q.push_back(cyc);
      end
      if (in_valid && in_ready) acc_cyc_q.push_back(cyc);
    end
  end

  // Present one operation and wait (bounded) until it is accepted.
  task automatic send(input logic [7:0] d, input int a, input logic r,
                      input logic [1:0] m, input logic [7:0] e, input bit expect_out);
    int cnt;
    in_valid = 1'b1;
    din      = d;
    sh_amt   = a[SHW-1:0];
    dir      = r;
    mode     = m;
    if (expect_out) exp_q.push_back(e);
    cnt = 0;
    @(negedge clk);
    while (!in_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 100) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 100) begin
      tick();
      cnt++;
    end
    check({"drain_", tag}, exp_q.size(), 32'd0);
  endtask

  // Single op with latency measurement from the acceptance cycle.
  task automatic single(input string tag, input logic [7:0] d, input int a,
                        input logic r, input logic [1:0] m, input logic [7:0] e);
    int lat;
    phase = tag;
    send(d, a, r, m, e, 1'b1);
    idle();
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({"latency_", tag}, lat, 32'd3);
    drain(tag);
  endtask

  logic [7:0] snap_dout;

  initial begin
    rst = 1'b1; in_valid = 1'b0; din = '0; sh_amt = '0; dir = 1'b0; mode = 2'b00;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_out_valid", {31'h0, out_valid}, 32'd0);
    check("reset_dout", {24'h0, dout}, 32'd0);
    check("reset_in_ready", {31'h0, in_ready}, 32'd1);
    out_ready = 1'b0;
    #1;
    check("idle_in_ready_no_out_ready", {31'h0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();

    // Directed single operations on 1001_0110
    single("rotl3", 8'h96, 3, 1'b0, 2'b00, 8'hB4);
    single("rotr1", 8'h96, 1, 1'b1, 2'b00, 8'h4B);
    single("lsl5",  8'h96, 5, 1'b0, 2'b01, 8'hC0);
    single("asr2",  8'h96, 2, 1'b1, 2'b10, 8'hE5);
    single("lsr2",  8'h96, 2, 1'b1, 2'b01, 8'h25);
    single("pass7", 8'h96, 7, 1'b0, 2'b11, 8'h96);
    single("asl1",  8'h96, 1, 1'b0, 2'b10, 8'h2C);
    single("pass3r", 8'h96, 3, 1'b1, 2'b11, 8'h96);

    // Streaming: 8 back-to-back rotates of 8'h01
    phase = "stream";
    out_cyc_q.delete();
    acc_cyc_q.delete();
    begin
      logic [7:0] stream_exp [8];
      stream_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      for (int i = 0; i < 8; i++) send(8'h01, i, 1'b0, 2'b00, stream_exp[i], 1'b1);
    end
    idle();
    drain("stream");
    check("stream_count", out_cyc_q.size(), 32'd8);
    if (out_cyc_q.size() == 8 && acc_cyc_q.size() == 8)
      for (int i = 0; i < 8; i++)
        check($sformatf("stream_timing_%0d", i), out_cyc_q[i] - acc_cyc_q[0], 3 + i);

    // Backpressure: 5 ops, out_ready low for 4 cycles mid-stream
    phase = "bp";
    out_cyc_q.delete();
    fork
      begin
        send(8'h96, 3, 1'b0, 2'b00, 8'hB4, 1'b1);
        send(8'h96, 1, 1'b1, 2'b00, 8'h4B, 1'b1);
        send(8'h96, 5, 1'b0, 2'b01, 8'hC0, 1'b1);
        send(8'h96, 2, 1'b1, 2'b10, 8'hE5, 1'b1);
        send(8'h96, 2, 1'b1, 2'b01, 8'h25, 1'b1);
        idle();
      end
      begin
        int cnt;
        cnt = 0;
        while (!out_valid && cnt < 50) begin
          tick();
          cnt++;
        end
        check("bp_first_valid", {31'h0, out_valid}, 32'd1);
        tick();
        out_ready = 1'b0;
        snap_dout = dout;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check($sformatf("bp_stall_valid_%0d", i), {31'h0, out_valid}, 32'd1);
          check($sformatf("bp_stall_dout_%0d", i), {24'h0, dout}, {24'h0, snap_dout});
          check($sformatf("bp_stall_in_ready_%0d", i), {31'h0, in_ready}, 32'd0);
          $display("[%0d] bp stall dout=0x%02h in_ready=%0b", cyc, dout, in_ready);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("bp");
    check("bp_count", out_cyc_q.size(), 32'd5);

    // Reset with two operations in flight
    phase = "rst_mid";
    tick();
    send(8'h96, 3, 1'b0, 2'b00, 8'h00, 1'b0);
    send(8'h96, 1, 1'b1, 2'b00, 8'h00, 1'b0);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_mid_dout", {24'h0, dout}, 32'd0);
    check("rst_mid_in_ready", {31'h0, in_ready}, 32'd1);
    $display("[%0d] rst_mid after reset out_valid=%0b dout=0x%02h", cyc, out_valid, dout);
    repeat (8) tick();
    check("rst_mid_queue", exp_q.size(), 32'd0);

    // Full sweep of all operand/amount/direction/mode combinations
    phase = "sweep";
    for (int d = 0; d < 256; d++)
      for (int a = 0; a < 8; a++)
        for (int r = 0; r < 2; r++)
          for (int m = 0; m < 4; m++)
            send(d[7:0], a, r[0], m[1:0], ref_op(d[7:0], a, r[0], m[1:0]), 1'b1);
    idle();
    drain("sweep");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Parametrised, pipelined barrel shifter/rotator with a valid/ready handshake on both sides. It generalises the 4-bit combinational left/right rotator to any power-of-two width, adds logical and arithmetic shift modes, and registers one shift stage per shift-amount bit. It sits between a producer and a consumer that both use valid/ready streaming, and it accepts one operation per cycle when not stalled.

## Interface
Parameters:
- WIDTH, 8, data width; power of two, at least 2.
- SHW, $clog2(WIDTH), shift-amount width. Derived; do not override.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents an operation.
- in_ready  output  1  block can accept an operation this cycle.
- din  input  WIDTH  operand.
- sh_amt  input  SHW  shift/rotate amount, 0..WIDTH-1.
- dir  input  1  0 = left, 1 = right.
- mode  input  2  00 rotate, 01 logical shift, 10 arithmetic shift, 11 pass-through.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- dout  output  WIDTH  result.

## Operation
- Pipeline structure:
  - SHW registered stages. Stage k (k = 0..SHW-1) applies a shift of 2^k when its captured sh_amt[k] = 1; otherwise it passes data through unchanged.
  - Each stage register holds: data, remaining sh_amt bits, dir, mode and a valid bit.
  - dout and out_valid are driven directly from the last stage register.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Global stall:
  - en = !out_valid || out_ready.
  - When en = 1, every stage loads from its predecessor. Stage 0 loads din/sh_amt/dir/mode and valid = in_valid.
  - When en = 0, all stages hold.
  - in_ready = en. This is a combinational path from out_ready and out_valid.
  - Bubbles are not squeezed out.
- Fill bits per mode:
  - Rotate: vacated bits take the bits shifted out from the opposite end (mod WIDTH).
  - Logical: vacated bits are 0.
  - Arithmetic right: vacated bits are copies of the original din[WIDTH-1]. Each stage uses the current MSB, which equals the original sign.
  - Arithmetic left: identical to logical left.
  - Pass-through (mode 11): dout = din regardless of sh_amt and dir.
- Shift amount:
  - sh_amt = 0 gives dout = din in every mode.
  - Amounts are always < WIDTH by construction; there is no saturation case.
- Rotate identity: rotate-left by n equals rotate-right by (WIDTH-n) mod WIDTH.
- Ordering: results leave in strict acceptance order; there is exactly one output per accepted input.
- Reset:
  - All stage valid bits clear to 0, so out_valid = 0 and in_ready = 1 in the first cycle after reset.
  - All data registers, including dout, clear to 0.
  - Operations in flight at reset are discarded with no output. Reset has priority over en.

## Timing
- Latency: exactly SHW cycles from an accepted input to out_valid on that result, with no stall. For WIDTH = 8 this is 3 cycles.
- Throughput: 1 operation per cycle while out_ready = 1.
- Under stall (out_valid = 1, out_ready = 0):
  - dout and out_valid hold stable.
  - in_ready = 0.
  - No input is accepted and no stage advances.
- Stall release: when out_ready rises, the held result transfers that cycle and the pipeline advances the same edge. Back-to-back results resume on following cycles.
- Input handling: in_valid may be deasserted at any time; invalid cycles propagate as bubbles (stage valid = 0). din, sh_amt, dir and mode are ignored when in_valid = 0 or in_ready = 0.
- Idle pipeline: with out_valid = 0, in_ready = 1 regardless of out_ready.

## Test plan
All scenarios use WIDTH = 8.
- Rotate: din = 8'b1001_0110, mode 00, dir 0, sh_amt 3 -> dout = 8'b1011_0100 exactly 3 cycles after acceptance. Same din, dir 1, sh_amt 1 -> 8'b0100_1011.
- Shift modes on din = 8'b1001_0110:
  - mode 01, dir 0, sh_amt 5 -> 8'b1100_0000.
  - mode 10, dir 1, sh_amt 2 -> 8'b1110_0101.
  - mode 01, dir 1, sh_amt 2 -> 8'b0010_0101.
  - mode 11, sh_amt 7 -> 8'b1001_0110.
- Streaming: 8 consecutive inputs, din = 8'h01, mode 00, dir 0, sh_amt = 0..7, with out_ready held at 1 -> outputs 8'h01, 02, 04, ... 80 on 8 consecutive cycles starting at cycle 3. No gaps.
- Backpressure: stream 5 operations and drop out_ready for 4 cycles mid-stream ->
  - dout/out_valid stable and in_ready = 0 throughout the stall.
  - All 5 results delivered in order with no loss or duplication.
- Reset mid-operation: accept 2 operations, assert rst on the next cycle ->
  - The following cycle: out_valid = 0, dout = 0, in_ready = 1.
  - Neither in-flight result ever appears.
- Exhaustive check: all din, sh_amt, dir and mode combinations, compared against a reference model -> zero mismatches. Include the sh_amt = 0 identity in every mode.
